vmem_port_scheduler: RTL and testbench
======================================

Name: vmem_port_scheduler

Overview:
- Arbitrates the single vector data-memory port between the vector reservation-station entries that have reached the memory stage.
- Grants one load or store at a time, round-robin.
- Sequences it as BEATS row accesses; each row is LANES x DATA_W and each beat has its own address taken from the LSQ entry.
- Returns load rows tagged with requester and beat, then pulses done so the RS entry can set its final memory flag.

Parameters:
NUM_REQ, 4, number of requesters (RS_v entries)
LANES, 8, 32-bit lanes per memory row
BEATS, 4, row accesses per vector instruction
ADDR_W, 8, data-memory row address width
DATA_W, 32, lane width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous abort of the current operation
req_valid  in  NUM_REQ  per-entry memory request
req_is_load  in  NUM_REQ  1=load, 0=store
req_addr  in  NUM_REQ*BEATS*ADDR_W  per-entry beat addresses; beat b of entry i is at [(i*BEATS+b)*ADDR_W +: ADDR_W]
st_wdata  in  LANES*DATA_W  store row supplied by the granted entry for the current beat
grant  out  NUM_REQ  one-hot owner; held for the whole operation
cur_beat  out  log2(BEATS)  beat being issued
mem_req  out  1  memory access strobe
mem_we  out  1  write enable; 1 only for stores
mem_addr  out  ADDR_W  row address
mem_wdata  out  LANES*DATA_W  combinational copy of st_wdata
mem_rdata  in  LANES*DATA_W  read row; valid the cycle after a read mem_req
ld_valid  out  1  load row return
ld_id  out  log2(NUM_REQ)  owning entry of the returned row
ld_beat  out  log2(BEATS)  beat of the returned row
ld_data  out  LANES*DATA_W  combinational copy of mem_rdata
done  out  1  one-cycle completion pulse
done_id  out  log2(NUM_REQ)  entry that completed

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0, except ld_data and mem_wdata, which are pass-throughs.
  - RR pointer = NUM_REQ-1, so entry 0 has highest priority first.
- FSM states: IDLE, ISSUE, LAST, DONE.
- IDLE:
  - If any req_valid, pick the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Register grant, owner id, is_load and all BEATS addresses of the winner.
  - Set pointer = winner, beat = 0, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - mem_req=1, mem_we=~is_load, mem_addr=latched addr[beat], cur_beat=beat.
  - beat increments each cycle.
  - After issuing beat BEATS-1, go to LAST.
- LAST: mem_req=0. For a load, the final row return occurs in this cycle. Go to DONE.
- DONE: done=1 and done_id=owner for exactly one cycle, grant cleared, go to IDLE.
- Load return timing:
  - ld_valid=1 the cycle after each read issue.
  - ld_beat and ld_id are the registered beat and owner of that read.
  - Beats return in order 0..BEATS-1.
- Timing contract: a request sampled in IDLE at cycle t gives:
  - mem_req at t+1..t+BEATS
  - load returns at t+2..t+BEATS+1
  - done at t+BEATS+2
  - next arbitration no earlier than t+BEATS+3
- Requester obligations:
  - Deassert req_valid in the cycle after seeing done.
  - Changes to req_valid, req_addr or req_is_load during an operation are ignored, because the operation runs on latched values.
- Stores: st_wdata must be valid in each issue cycle; the block does not register it.
- Flush, in any state:
  - Next state IDLE; grant, mem_req, ld_valid and done all 0.
  - A pending read return is suppressed.
  - The RR pointer is kept.
  - Flush takes priority over arbitration in the same cycle.
- rst has priority over flush.
- Beat counter: wraps BEATS-1 -> 0 only through a new grant, never mid-operation.
- Invariant: grant is one-hot or zero; mem_req is never high outside ISSUE.

Test Plan:
- Reset, then req_valid=0001 load, addrs {0x10,0x11,0x12,0x13} -> mem_req at t+1..t+4 with those addrs and mem_we=0; ld_valid at t+2..t+5 with ld_beat 0..3, ld_id=0; done, done_id=0 at t+6.
- Store from entry 2, addrs {0x20..0x23}, st_wdata changing per beat -> mem_we=1 for 4 cycles; mem_wdata tracks st_wdata; no ld_valid; done_id=2.
- req_valid=1111 held, each requester dropping only its own bit after its done -> grant order 0,1,2,3. A fresh 1111 after that -> 0 first again (pointer=3).
- With pointer=1, req_valid=1001 -> entry 3 granted before entry 0.
- flush asserted in the cycle after beat 1 issue of a load -> next cycle mem_req=0, no ld_valid for beat 1, no done; a later request still arbitrates normally.
- rst asserted mid-ISSUE -> all outputs 0 next cycle; pointer=3; req_valid=0100 then grants entry 2.

Source files
------------

// File: rtl/vmem_port_scheduler.sv
// vmem_port_scheduler
// Round-robin owner of the single vector data-memory port. One granted
// reservation-station entry at a time is sequenced through BEATS row accesses
// using the beat addresses latched at grant. Load rows are tagged with owner
// and beat on the way back, and a done pulse closes each operation.
module vmem_port_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LANES   = 8,
    parameter int BEATS   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_is_load,
    input  logic [NUM_REQ*BEATS*ADDR_W-1:0]  req_addr,
    input  logic [LANES*DATA_W-1:0]          st_wdata,
    output logic [NUM_REQ-1:0]               grant,
    output logic [BEAT_W-1:0]                cur_beat,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [LANES*DATA_W-1:0]          mem_wdata,
    input  logic [LANES*DATA_W-1:0]          mem_rdata,
    output logic                             ld_valid,
    output logic [ID_W-1:0]                  ld_id,
    output logic [BEAT_W-1:0]                ld_beat,
    output logic [LANES*DATA_W-1:0]          ld_data,
    output logic                             done,
    output logic [ID_W-1:0]                  done_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, LAST, DONE} state_t;

    state_t              state_reg;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     owner_reg;
    logic [NUM_REQ-1:0]  grant_reg;
    logic [BEAT_W-1:0]   cur_beat_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic                ld_valid_reg;
    logic [ID_W-1:0]     ld_id_reg;
    logic [BEAT_W-1:0]   ld_beat_reg;
    logic                done_reg;
    logic [ID_W-1:0]     done_id_reg;

    logic [ADDR_W-1:0]   addr_lat [BEATS];
    logic [ADDR_W-1:0]   req_addr_arr [NUM_REQ][BEATS];
    logic [ID_W-1:0]     rr_idx [NUM_REQ];
    logic                arb_found;
    logic [ID_W-1:0]     arb_win;
    logic                take_grant;

    genvar gi, gb;

    // Unpack the flat address bus into [entry][beat]
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            for (gb = 0; gb < BEATS; gb++) begin : g_beat
                assign req_addr_arr[gi][gb] = req_addr[(gi*BEATS+gb)*ADDR_W +: ADDR_W];
            end
        end
    endgenerate

    // rr_idx[k] is the entry examined k+1 places after the pointer, wrapped
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rr
            logic [ID_W:0] rr_raw;
            assign rr_raw     = {1'b0, ptr_reg} + (ID_W+1)'(gi + 1);
            assign rr_idx[gi] = (rr_raw >= (ID_W+1)'(NUM_REQ))
                              ? ID_W'(rr_raw - (ID_W+1)'(NUM_REQ))
                              : ID_W'(rr_raw);
        end
    endgenerate

    // Pick the nearest requester after the pointer (lowest offset wins)
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx[k]]) begin
                arb_found = 1'b1;
                arb_win   = rr_idx[k];
            end
        end
    end

    assign take_grant = (state_reg == IDLE) && arb_found && !flush;

    // Snapshot every beat address of the winner so requester changes are ignored
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_lat
            always_ff @(posedge clk) begin
                if (rst) begin
                    addr_lat[gi] <= '0;
                end else if (take_grant) begin
                    addr_lat[gi] <= req_addr_arr[arb_win][gi];
                end
            end
        end
    endgenerate

    // Operation FSM with registered port outputs; flush aborts but keeps the pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= ID_W'(NUM_REQ - 1);
            owner_reg    <= '0;
            grant_reg    <= '0;
            cur_beat_reg <= '0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            ld_valid_reg <= 1'b0;
            ld_id_reg    <= '0;
            ld_beat_reg  <= '0;
            done_reg     <= 1'b0;
            done_id_reg  <= '0;
        end else if (flush) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            mem_req_reg  <= 1'b0;
            mem_we_reg   <= 1'b0;
            ld_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            // A read issued this cycle returns its row next cycle
            ld_valid_reg <= mem_req_reg && !mem_we_reg;
            if (mem_req_reg && !mem_we_reg) begin
                ld_id_reg   <= owner_reg;
                ld_beat_reg <= cur_beat_reg;
            end
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (arb_found) begin
                        grant_reg    <= NUM_REQ'(1) << arb_win;
                        owner_reg    <= arb_win;
                        ptr_reg      <= arb_win;
                        cur_beat_reg <= '0;
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= !req_is_load[arb_win];
                        mem_addr_reg <= req_addr_arr[arb_win][0];
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_beat_reg == BEAT_W'(BEATS - 1)) begin
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= LAST;
                    end else begin
                        cur_beat_reg <= cur_beat_reg + BEAT_W'(1);
                        mem_addr_reg <= addr_lat[cur_beat_reg + BEAT_W'(1)];
                    end
                end
                LAST: begin
                    done_reg    <= 1'b1;
                    done_id_reg <= owner_reg;
                    grant_reg   <= '0;
                    state_reg   <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_reg;
    assign cur_beat  = cur_beat_reg;
    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = st_wdata;
    assign ld_valid  = ld_valid_reg;
    assign ld_id     = ld_id_reg;
    assign ld_beat   = ld_beat_reg;
    assign ld_data   = mem_rdata;
    assign done      = done_reg;
    assign done_id   = done_id_reg;

endmodule

// File: tb/tb_vmem_port_scheduler.sv
// Testbench for vmem_port_scheduler: a negedge monitor records every memory
// issue, load return and done pulse; a transaction-level model predicts the
// same events from the arbitration order and the timing contract.
module tb_vmem_port_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LANES   = 8;
    localparam int BEATS   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int ROW_W   = LANES * DATA_W;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            flush;
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_is_load;
    logic [NUM_REQ*BEATS*ADDR_W-1:0] req_addr;
    logic [ROW_W-1:0]                st_wdata;
    logic [NUM_REQ-1:0]              grant;
    logic [1:0]                      cur_beat;
    logic                            mem_req;
    logic                            mem_we;
    logic [ADDR_W-1:0]               mem_addr;
    logic [ROW_W-1:0]                mem_wdata;
    logic [ROW_W-1:0]                mem_rdata;
    logic                            ld_valid;
    logic [1:0]                      ld_id;
    logic [1:0]                      ld_beat;
    logic [ROW_W-1:0]                ld_data;
    logic                            done;
    logic [1:0]                      done_id;

    // kind: 0 = memory issue, 1 = load return, 2 = done pulse
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic [1:0]  beat;
        logic        we;
        logic [7:0]  addr;
        logic        data_bad;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  got_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model_ptr;
    logic [7:0] tbl_addr [4][4];
    logic       tbl_load [4];

    vmem_port_scheduler #(
        .NUM_REQ(NUM_REQ), .LANES(LANES), .BEATS(BEATS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_is_load(req_is_load), .req_addr(req_addr),
        .st_wdata(st_wdata), .grant(grant), .cur_beat(cur_beat),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .ld_valid(ld_valid), .ld_id(ld_id), .ld_beat(ld_beat),
        .ld_data(ld_data), .done(done), .done_id(done_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Fresh random store/read rows every cycle
    initial begin
        st_wdata  = '0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int w = 0; w < LANES; w++) begin
                st_wdata[w*DATA_W +: DATA_W]  = $urandom();
                mem_rdata[w*DATA_W +: DATA_W] = $urandom();
            end
        end
    end

    // Record observable events mid-cycle
    always @(negedge clk) begin
        if (mem_req)
            got_q.push_back(ev_t'{2'd0, 32'(cyc), grant, 2'd0, cur_beat, mem_we, mem_addr,
                                  |(mem_wdata ^ st_wdata)});
        if (ld_valid)
            got_q.push_back(ev_t'{2'd1, 32'(cyc), 4'd0, ld_id, ld_beat, 1'b0, 8'd0,
                                  |(ld_data ^ mem_rdata)});
        if (done)
            got_q.push_back(ev_t'{2'd2, 32'(cyc), 4'd0, done_id, 2'd0, 1'b0, 8'd0, 1'b0});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester after the pointer, wrapping
    function automatic int pick(input int p, input logic [3:0] m);
        for (int k = 1; k <= NUM_REQ; k++)
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return -1;
    endfunction

    // Expected events of one operation granted to w, sampled at cycle t
    task automatic predict(input int t, input int w);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4)
                exp_q.push_back(ev_t'{2'd0, 32'(t + c), 4'(1 << w), 2'd0, 2'(c - 1),
                                      !tbl_load[w], tbl_addr[w][c - 1], 1'b0});
            if (tbl_load[w] && c >= 2 && c <= 5)
                exp_q.push_back(ev_t'{2'd1, 32'(t + c), 4'd0, 2'(w), 2'(c - 2),
                                      1'b0, 8'd0, 1'b0});
            if (c == 6)
                exp_q.push_back(ev_t'{2'd2, 32'(t + c), 4'd0, 2'(w), 2'd0,
                                      1'b0, 8'd0, 1'b0});
        end
    endtask

    task automatic randomize_tables();
        for (int i = 0; i < NUM_REQ; i++) begin
            tbl_load[i] = 1'($urandom());
            for (int b = 0; b < BEATS; b++) tbl_addr[i][b] = 8'($urandom());
        end
    endtask

    // Hold mask; each requester drops its bit the cycle after its done.
    // Address/type inputs carry real values only at arbitration cycles.
    task automatic run_ops(input logic [3:0] mask);
        int t;
        int w;
        int drop_at [4];
        int arb_q[$];
        logic [3:0] m;
        int end_cyc;
        bit hit;
        m = mask;
        t = cyc;
        for (int i = 0; i < NUM_REQ; i++) drop_at[i] = 32'h7fffffff;
        while (m != 4'd0) begin
            w = pick(model_ptr, m);
            predict(t, w);
            arb_q.push_back(t);
            model_ptr  = w;
            drop_at[w] = t + 7;
            m[w]       = 1'b0;
            t          = t + 7;
        end
        end_cyc = t + 3;
        while (cyc < end_cyc) begin
            hit = 1'b0;
            foreach (arb_q[k]) if (arb_q[k] == cyc) hit = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) req_valid[i] = mask[i] && (cyc < drop_at[i]);
            if (hit) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_is_load[i] = tbl_load[i];
                    for (int b = 0; b < BEATS; b++) req_addr[(i*BEATS+b)*ADDR_W +: ADDR_W] = tbl_addr[i][b];
                end
            end else begin
                req_addr    = {$urandom(), $urandom(), $urandom(), $urandom()};
                req_is_load = 4'($urandom());
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic drive_tables();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_is_load[i] = tbl_load[i];
            for (int b = 0; b < BEATS; b++) req_addr[(i*BEATS+b)*ADDR_W +: ADDR_W] = tbl_addr[i][b];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp += 12;
        if (grant !== 4'd0)          begin n_fail++; $display("FAIL reset_grant: got %h want 0", grant); end
        if (mem_req !== 1'b0)        begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        if (mem_we !== 1'b0)         begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        if (mem_addr !== 8'd0)       begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        if (cur_beat !== 2'd0)       begin n_fail++; $display("FAIL reset_cur_beat: got %0d want 0", cur_beat); end
        if (ld_valid !== 1'b0)       begin n_fail++; $display("FAIL reset_ld_valid: got %b want 0", ld_valid); end
        if (ld_id !== 2'd0)          begin n_fail++; $display("FAIL reset_ld_id: got %0d want 0", ld_id); end
        if (ld_beat !== 2'd0)        begin n_fail++; $display("FAIL reset_ld_beat: got %0d want 0", ld_beat); end
        if (done !== 1'b0)           begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (done_id !== 2'd0)        begin n_fail++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
        if (mem_wdata !== st_wdata)  begin n_fail++; $display("FAIL reset_mem_wdata: pass-through differs"); end
        if (ld_data !== mem_rdata)   begin n_fail++; $display("FAIL reset_ld_data: pass-through differs"); end
        repeat (3) tick();
        n_cmp++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_idle: got %0d events want 0", got_q.size()); end
        $display("test_reset: done");
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_load();
        ev_t e, g;
        tbl_load[0] = 1'b1;
        for (int b = 0; b < BEATS; b++) tbl_addr[0][b] = 8'h10 + 8'(b);
        run_ops(4'b0001);
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL load_seq: got %h want %h", g, e); end
        end
        $display("test_load: entry 0 load finished");
    endtask

    task automatic test_store();
        ev_t e, g;
        tbl_load[2] = 1'b0;
        for (int b = 0; b < BEATS; b++) tbl_addr[2][b] = 8'h20 + 8'(b);
        run_ops(4'b0100);
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL store_seq: got %h want %h", g, e); end
        end
        $display("test_store: entry 2 store finished");
    endtask

    task automatic test_rr();
        ev_t e, g;
        randomize_tables();
        run_ops(4'b1000);
        run_ops(4'b1111);
        run_ops(4'b1111);
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL rr_seq: got %h want %h", g, e); end
        end
        $display("test_rr: round-robin sweeps finished");
    endtask

    // Flush after beat 1 of a load; pointer survives, so 1001 then grants 3 before 0
    task automatic test_flush();
        ev_t e, g;
        bit seen;
        randomize_tables();
        tbl_load[1] = 1'b1;
        drive_tables();
        req_valid = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_req && cur_beat == 2'd1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL flush_wait: beat 1 issue not seen within 20 cycles"); end
        model_ptr = 1;
        flush     = 1'b1;
        req_valid = '0;
        tick();
        flush = 1'b0;
        n_cmp += 4;
        if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL flush_mem_req: got %b want 0", mem_req); end
        if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ld_valid: got %b want 0", ld_valid); end
        if (grant !== 4'd0)    begin n_fail++; $display("FAIL flush_grant: got %h want 0", grant); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL flush_done: got %b want 0", done); end
        got_q.delete();
        repeat (10) tick();
        n_cmp++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_quiet: got %0d events want 0", got_q.size()); end
        got_q.delete();
        exp_q.delete();
        run_ops(4'b1001);
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL flush_after_seq: got %h want %h", g, e); end
        end
        $display("test_flush: flush and follow-up arbitration finished");
    endtask

    // Reset mid-issue; pointer returns to 3 so 0101 grants 0 before 2
    task automatic test_reset_mid();
        ev_t e, g;
        bit seen;
        randomize_tables();
        drive_tables();
        req_valid = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (mem_req && cur_beat == 2'd2) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_wait: beat 2 issue not seen within 20 cycles"); end
        rst       = 1'b1;
        req_valid = '0;
        tick();
        n_cmp += 6;
        if (grant !== 4'd0)    begin n_fail++; $display("FAIL rstmid_grant: got %h want 0", grant); end
        if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
        if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); end
        if (cur_beat !== 2'd0) begin n_fail++; $display("FAIL rstmid_cur_beat: got %0d want 0", cur_beat); end
        if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ld_valid: got %b want 0", ld_valid); end
        if (done !== 1'b0)     begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        rst       = 1'b0;
        model_ptr = 3;
        got_q.delete();
        exp_q.delete();
        run_ops(4'b0101);
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            g = (got_q.size() > 0) ? got_q.pop_front() : '1;
            n_cmp++;
            if (g !== e) begin n_fail++; $display("FAIL rstmid_after_seq: got %h want %h", g, e); end
        end
        $display("test_reset_mid: reset recovery finished");
    endtask

    task automatic test_random();
        ev_t e, g;
        logic [3:0] mask;
        for (int r = 0; r < 8; r++) begin
            randomize_tables();
            mask = 4'($urandom_range(1, 15));
            run_ops(mask);
            while (exp_q.size() > 0 || got_q.size() > 0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                g = (got_q.size() > 0) ? got_q.pop_front() : '1;
                n_cmp++;
                if (g !== e) begin n_fail++; $display("FAIL random_seq: round %0d got %h want %h", r, g, e); end
            end
            $display("test_random: round %0d mask %b finished", r, mask);
        end
    endtask

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        req_valid   = '0;
        req_is_load = '0;
        req_addr    = '0;
        model_ptr   = NUM_REQ - 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            tbl_load[i] = 1'b0;
            for (int b = 0; b < BEATS; b++) tbl_addr[i][b] = 8'd0;
        end
        test_reset();
        test_load();
        test_store();
        test_rr();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
